tcp_conn_controller: RTL and testbench

TCP_CONN_CONTROLLER -- requirements
Module: tcp_conn_controller

---
 rtl/tcp_conn_if.sv | 31 +++
 rtl/tcp_conn_controller.sv | 226 ++++++++++++++++++++++
 tb/tb_tcp_conn_controller.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcp_conn_if.sv
// Segment-metadata and response-request bundle between the TCP parser/transmitter and the connection controller.

interface tcp_conn_if;
    logic        meta_valid;
    logic        meta_ready;
    logic [15:0] meta_src_port;
    logic [15:0] meta_dst_port;
    logic [31:0] meta_seq_num;
    logic [31:0] meta_ack_num;
    logic [7:0]  meta_flags;
    logic [15:0] meta_payload_len;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_flags;
    logic [31:0] tx_seq;
    logic [31:0] tx_ack;
    logic [15:0] tx_src_port;
    logic [15:0] tx_dst_port;

    modport master (
        output meta_valid, meta_src_port, meta_dst_port, meta_seq_num, meta_ack_num,
               meta_flags, meta_payload_len, tx_ready,
        input  meta_ready, tx_valid, tx_flags, tx_seq, tx_ack, tx_src_port, tx_dst_port
    );

    modport slave (
        input  meta_valid, meta_src_port, meta_dst_port, meta_seq_num, meta_ack_num,
               meta_flags, meta_payload_len, tx_ready,
        output meta_ready, tx_valid, tx_flags, tx_seq, tx_ack, tx_src_port, tx_dst_port
    );
endinterface

// File: rtl/tcp_conn_controller.sv
// Single-connection passive-open TCP controller: SYN/SYN-ACK handshake, in-order data ACKs,
// duplicate ACKs for out-of-order data, passive close, RST handling and handshake/close timeout.

module tcp_conn_controller #(
    parameter logic [31:0] ISN            = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_enable,
    input  logic [15:0] cfg_local_port,
    tcp_conn_if.slave   seg,
    output logic [2:0]  conn_state,
    output logic        payload_accept,
    output logic [15:0] drop_count
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_CLOSED      = 3'd0,
        ST_LISTEN      = 3'd1,
        ST_SYN_RCVD    = 3'd2,
        ST_ESTABLISHED = 3'd3,
        ST_LAST_ACK    = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   rcv_nxt_q, rcv_nxt_d;
    logic [31:0]   snd_nxt_q, snd_nxt_d;
    logic [15:0]   remote_port_q, remote_port_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          tx_valid_q, tx_valid_d;
    logic [7:0]    tx_flags_q, tx_flags_d;
    logic [31:0]   tx_seq_q, tx_seq_d;
    logic [31:0]   tx_ack_q, tx_ack_d;
    logic [15:0]   tx_src_port_q, tx_src_port_d;
    logic [15:0]   tx_dst_port_q, tx_dst_port_d;
    logic          payload_accept_q, payload_accept_d;
    logic [15:0]   drop_count_q, drop_count_d;

    logic          hs_s, in_conn_s, matched_s, in_order_s, has_payload_s, drop_s;
    logic          fin_s, syn_s, rst_s, ack_s;
    logic [31:0]   rcv_adv_s;
    logic          flags_unused_s;

    assign fin_s          = seg.meta_flags[0];
    assign syn_s          = seg.meta_flags[1];
    assign rst_s          = seg.meta_flags[2];
    assign ack_s          = seg.meta_flags[4];
    assign flags_unused_s = ^{seg.meta_flags[7:5], seg.meta_flags[3]};

    // A segment is only taken while no response is waiting, so at most one response is ever in flight.
    assign hs_s          = seg.meta_valid && !tx_valid_q;
    assign in_conn_s     = (state_q == ST_SYN_RCVD) || (state_q == ST_ESTABLISHED) || (state_q == ST_LAST_ACK);
    assign matched_s     = hs_s && (seg.meta_dst_port == cfg_local_port) &&
                           (!in_conn_s || (seg.meta_src_port == remote_port_q));
    assign in_order_s    = (seg.meta_seq_num == rcv_nxt_q);
    assign has_payload_s = (seg.meta_payload_len != 16'h0000);
    assign rcv_adv_s     = rcv_nxt_q + {16'h0000, seg.meta_payload_len} + {31'h0000_0000, fin_s};

    // Segment decision, response loading, timeout and drop accounting.
    always_comb begin
        state_d          = state_q;
        rcv_nxt_d        = rcv_nxt_q;
        snd_nxt_d        = snd_nxt_q;
        remote_port_d    = remote_port_q;
        tx_valid_d       = tx_valid_q && !seg.tx_ready;
        tx_flags_d       = tx_flags_q;
        tx_seq_d         = tx_seq_q;
        tx_ack_d         = tx_ack_q;
        tx_src_port_d    = tx_src_port_q;
        tx_dst_port_d    = tx_dst_port_q;
        payload_accept_d = 1'b0;
        drop_s           = 1'b0;
        timer_d          = timer_q;
        drop_count_d     = drop_count_q;

        if (!cfg_enable && !tx_valid_q) begin
            state_d       = ST_CLOSED;
            rcv_nxt_d     = 32'h0000_0000;
            snd_nxt_d     = 32'h0000_0000;
            remote_port_d = 16'h0000;
            drop_s        = hs_s;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    drop_s  = hs_s;
                    state_d = cfg_enable ? ST_LISTEN : ST_CLOSED;
                end
                ST_LISTEN: begin
                    if (matched_s && syn_s && !ack_s && !rst_s) begin
                        state_d       = ST_SYN_RCVD;
                        remote_port_d = seg.meta_src_port;
                        rcv_nxt_d     = seg.meta_seq_num + 32'd1;
                        snd_nxt_d     = ISN + 32'd1;
                        tx_valid_d    = 1'b1;
                        tx_flags_d    = 8'h12;
                        tx_seq_d      = ISN;
                        tx_ack_d      = seg.meta_seq_num + 32'd1;
                        tx_src_port_d = cfg_local_port;
                        tx_dst_port_d = seg.meta_src_port;
                    end else begin
                        drop_s = hs_s;
                    end
                end
                ST_SYN_RCVD, ST_LAST_ACK: begin
                    if (matched_s && rst_s) begin
                        state_d = ST_LISTEN;
                    end else if (matched_s && ack_s && (seg.meta_ack_num == snd_nxt_q)) begin
                        state_d = (state_q == ST_SYN_RCVD) ? ST_ESTABLISHED : ST_LISTEN;
                    end else begin
                        drop_s = hs_s;
                        // A matched segment restarts the timer, so it can never expire in that cycle.
                        if (!matched_s && (timer_q == TIMER_LAST)) begin
                            state_d = ST_LISTEN;
                        end else begin
                            state_d = state_q;
                        end
                    end
                end
                ST_ESTABLISHED: begin
                    if (matched_s && rst_s) begin
                        state_d = ST_LISTEN;
                    end else if (matched_s && in_order_s) begin
                        rcv_nxt_d        = rcv_adv_s;
                        payload_accept_d = has_payload_s;
                        if (fin_s) begin
                            state_d       = ST_LAST_ACK;
                            snd_nxt_d     = snd_nxt_q + 32'd1;
                            tx_valid_d    = 1'b1;
                            tx_flags_d    = 8'h11;
                            tx_seq_d      = snd_nxt_q;
                            tx_ack_d      = rcv_adv_s;
                            tx_src_port_d = cfg_local_port;
                            tx_dst_port_d = remote_port_q;
                        end else if (has_payload_s) begin
                            tx_valid_d    = 1'b1;
                            tx_flags_d    = 8'h10;
                            tx_seq_d      = snd_nxt_q;
                            tx_ack_d      = rcv_adv_s;
                            tx_src_port_d = cfg_local_port;
                            tx_dst_port_d = remote_port_q;
                        end else begin
                            state_d = state_q;
                        end
                    end else if (matched_s) begin
                        drop_s        = 1'b1;
                        tx_valid_d    = 1'b1;
                        tx_flags_d    = 8'h10;
                        tx_seq_d      = snd_nxt_q;
                        tx_ack_d      = rcv_nxt_q;
                        tx_src_port_d = cfg_local_port;
                        tx_dst_port_d = remote_port_q;
                    end else begin
                        drop_s = hs_s;
                    end
                end
                default: begin
                    state_d = ST_CLOSED;
                    drop_s  = hs_s;
                end
            endcase
        end

        if (matched_s || (state_d != state_q)) begin
            timer_d = '0;
        end else if ((state_q == ST_SYN_RCVD) || (state_q == ST_LAST_ACK)) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end

        if (drop_s && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // State, connection context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_CLOSED;
            rcv_nxt_q        <= 32'h0000_0000;
            snd_nxt_q        <= 32'h0000_0000;
            remote_port_q    <= 16'h0000;
            timer_q          <= '0;
            tx_valid_q       <= 1'b0;
            tx_flags_q       <= 8'h00;
            tx_seq_q         <= 32'h0000_0000;
            tx_ack_q         <= 32'h0000_0000;
            tx_src_port_q    <= 16'h0000;
            tx_dst_port_q    <= 16'h0000;
            payload_accept_q <= 1'b0;
            drop_count_q     <= 16'h0000;
        end else begin
            state_q          <= state_d;
            rcv_nxt_q        <= rcv_nxt_d;
            snd_nxt_q        <= snd_nxt_d;
            remote_port_q    <= remote_port_d;
            timer_q          <= timer_d;
            tx_valid_q       <= tx_valid_d;
            tx_flags_q       <= tx_flags_d;
            tx_seq_q         <= tx_seq_d;
            tx_ack_q         <= tx_ack_d;
            tx_src_port_q    <= tx_src_port_d;
            tx_dst_port_q    <= tx_dst_port_d;
            payload_accept_q <= payload_accept_d;
            drop_count_q     <= drop_count_d;
        end
    end

    assign seg.meta_ready  = !tx_valid_q;
    assign seg.tx_valid    = tx_valid_q;
    assign seg.tx_flags    = tx_flags_q;
    assign seg.tx_seq      = tx_seq_q;
    assign seg.tx_ack      = tx_ack_q;
    assign seg.tx_src_port = tx_src_port_q;
    assign seg.tx_dst_port = tx_dst_port_q;
    assign conn_state      = state_q;
    assign payload_accept  = payload_accept_q;
    assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_tcp_conn_controller.sv
// Bench for tcp_conn_controller: directed connection lifecycle with literal expectations, then
// randomized segments checked every cycle against a transaction-level connection model.

module tb_tcp_conn_controller;

    localparam int unsigned TO    = 16;
    localparam logic [31:0] ISN   = 32'h0000_1000;
    localparam logic [15:0] LPORT = 16'd80;
    localparam logic [15:0] RPORT = 16'd1234;

    logic        clk;
    logic        rst_n;
    logic        cfg_enable;
    logic [15:0] cfg_local_port;
    logic [2:0]  conn_state;
    logic        payload_accept;
    logic [15:0] drop_count;

    tcp_conn_if bus ();

    tcp_conn_controller #(.ISN(ISN), .TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_enable     (cfg_enable),
        .cfg_local_port (cfg_local_port),
        .seg            (bus),
        .conn_state     (conn_state),
        .payload_accept (payload_accept),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    // Connection model: state number, sequence context, pending response and counters.
    int          m_st;
    int          m_timer;
    logic [31:0] m_rcv, m_snd;
    logic [15:0] m_rport, m_drop;
    logic        m_txv, m_pa;
    logic [7:0]  m_fl;
    logic [31:0] m_tseq, m_tack;
    logic [15:0] m_tsrc, m_tdst;

    function automatic void m_reset();
        m_st = 0; m_timer = 0; m_rcv = 32'h0; m_snd = 32'h0; m_rport = 16'h0; m_drop = 16'h0;
        m_txv = 1'b0; m_pa = 1'b0; m_fl = 8'h0; m_tseq = 32'h0; m_tack = 32'h0;
        m_tsrc = 16'h0; m_tdst = 16'h0;
    endfunction

    function automatic void m_emit(input logic [7:0] fl, input logic [31:0] sq, input logic [31:0] ak);
        m_txv = 1'b1; m_fl = fl; m_tseq = sq; m_tack = ak; m_tsrc = cfg_local_port; m_tdst = m_rport;
    endfunction

    function automatic void model_step();
        logic hs, matched, pend, drop, fin, syn, rst, ack;
        int   prev;
        if (!rst_n) begin
            m_reset();
            return;
        end
        fin  = bus.meta_flags[0];
        syn  = bus.meta_flags[1];
        rst  = bus.meta_flags[2];
        ack  = bus.meta_flags[4];
        pend = m_txv;
        prev = m_st;
        hs   = bus.meta_valid && !pend;
        matched = hs && (bus.meta_dst_port == cfg_local_port) &&
                  ((m_st < 2) || (bus.meta_src_port == m_rport));
        drop = 1'b0;
        m_pa = 1'b0;
        if (pend && bus.tx_ready) m_txv = 1'b0;

        if (!cfg_enable && !pend) begin
            m_st = 0; m_rcv = 32'h0; m_snd = 32'h0; m_rport = 16'h0; drop = hs;
        end else if (m_st == 0) begin
            drop = hs;
            if (cfg_enable) m_st = 1;
        end else if (m_st == 1) begin
            if (matched && syn && !ack && !rst) begin
                m_rport = bus.meta_src_port;
                m_rcv   = bus.meta_seq_num + 32'd1;
                m_snd   = ISN + 32'd1;
                m_emit(8'h12, ISN, m_rcv);
                m_st    = 2;
            end else drop = hs;
        end else if (matched && rst) begin
            m_st = 1;
        end else if (m_st == 3) begin
            if (!matched) drop = hs;
            else if (bus.meta_seq_num == m_rcv) begin
                m_rcv = m_rcv + 32'(bus.meta_payload_len) + 32'(fin);
                m_pa  = (bus.meta_payload_len != 16'd0);
                if (fin) begin
                    m_emit(8'h11, m_snd, m_rcv);
                    m_snd = m_snd + 32'd1;
                    m_st  = 4;
                end else if (m_pa) m_emit(8'h10, m_snd, m_rcv);
            end else begin
                drop = 1'b1;
                m_emit(8'h10, m_snd, m_rcv);
            end
        end else begin
            if (matched && ack && (bus.meta_ack_num == m_snd)) m_st = (m_st == 2) ? 3 : 1;
            else begin
                drop = hs;
                if (!matched && (m_timer == int'(TO) - 1)) m_st = 1;
            end
        end

        if (matched || (m_st != prev) || !((m_st == 2) || (m_st == 4))) m_timer = 0;
        else m_timer++;
        if (drop && (m_drop != 16'hFFFF)) m_drop++;
    endfunction

    // Advance the model on each edge and compare all outputs just after it.
    always begin
        @(posedge clk);
        model_step();
        #1;
        check("state", 32'(conn_state), 32'(m_st));
        check("meta_ready", 32'(bus.meta_ready), 32'(!m_txv));
        check("tx_valid", 32'(bus.tx_valid), 32'(m_txv));
        check("payload_accept", 32'(payload_accept), 32'(m_pa));
        check("drop_count", 32'(drop_count), 32'(m_drop));
        if (m_txv) begin
            check("tx_flags", 32'(bus.tx_flags), 32'(m_fl));
            check("tx_seq", bus.tx_seq, m_tseq);
            check("tx_ack", bus.tx_ack, m_tack);
            check("tx_src_port", 32'(bus.tx_src_port), 32'(m_tsrc));
            check("tx_dst_port", 32'(bus.tx_dst_port), 32'(m_tdst));
        end
    end

    task automatic send_seg(input logic [15:0] src, input logic [15:0] dst, input logic [31:0] seq,
                            input logic [31:0] ackn, input logic [7:0] fl, input logic [15:0] len);
        @(negedge clk);
        for (int k = 0; k < 40 && !bus.meta_ready; k++) @(negedge clk);
        if (!bus.meta_ready) check("meta_ready_timeout", 32'(bus.meta_ready), 32'd1);
        bus.meta_src_port    = src;
        bus.meta_dst_port    = dst;
        bus.meta_seq_num     = seq;
        bus.meta_ack_num     = ackn;
        bus.meta_flags       = fl;
        bus.meta_payload_len = len;
        bus.meta_valid       = 1'b1;
        @(negedge clk);
        bus.meta_valid       = 1'b0;
    endtask

    task automatic drain_tx();
        bus.tx_ready = 1'b1;
        for (int k = 0; k < 20 && bus.tx_valid; k++) @(negedge clk);
        if (bus.tx_valid) check("tx_drain_timeout", 32'(bus.tx_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_enable = 1'b0; cfg_local_port = LPORT;
        bus.meta_valid = 1'b0; bus.meta_src_port = 16'h0; bus.meta_dst_port = 16'h0;
        bus.meta_seq_num = 32'h0; bus.meta_ack_num = 32'h0; bus.meta_flags = 8'h0;
        bus.meta_payload_len = 16'h0; bus.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(conn_state), 32'd0);
        check("rst_meta_ready", 32'(bus.meta_ready), 32'd1);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("closed_while_disabled", 32'(conn_state), 32'd0);
        cfg_enable = 1'b1;
        @(negedge clk);
        check("listen_after_enable", 32'(conn_state), 32'd1);

        // Open.
        bus.tx_ready = 1'b0;
        send_seg(RPORT, LPORT, 32'd100, 32'd0, 8'h02, 16'd0);
        check("synack_flags", 32'(bus.tx_flags), 32'h12);
        check("synack_seq", bus.tx_seq, 32'h0000_1000);
        check("synack_ack", bus.tx_ack, 32'd101);
        check("synack_dst", 32'(bus.tx_dst_port), 32'd1234);
        check("syn_rcvd_state", 32'(conn_state), 32'd2);
        drain_tx();
        send_seg(RPORT, LPORT, 32'd101, 32'h0000_1001, 8'h10, 16'd0);
        check("established_state", 32'(conn_state), 32'd3);
        check("established_no_tx", 32'(bus.tx_valid), 32'd0);

        // In-order data with back-pressure.
        bus.tx_ready = 1'b0;
        send_seg(RPORT, LPORT, 32'd101, 32'h0000_1001, 8'h10, 16'd10);
        check("data_payload_accept", 32'(payload_accept), 32'd1);
        check("data_ack", bus.tx_ack, 32'd111);
        check("data_seq", bus.tx_seq, 32'h0000_1001);
        check("data_flags", 32'(bus.tx_flags), 32'h10);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_tx_valid", 32'(bus.tx_valid), 32'd1);
            check("hold_tx_ack", bus.tx_ack, 32'd111);
            check("hold_meta_ready", 32'(bus.meta_ready), 32'd0);
            check("hold_pulse_low", 32'(payload_accept), 32'd0);
        end
        drain_tx();

        // Out-of-order and wrong port.
        send_seg(RPORT, LPORT, 32'd200, 32'h0000_1001, 8'h10, 16'd5);
        check("dupack_ack", bus.tx_ack, 32'd111);
        check("dupack_drop_count", 32'(drop_count), 32'd1);
        check("dupack_no_pulse", 32'(payload_accept), 32'd0);
        send_seg(RPORT, 16'd81, 32'd111, 32'h0000_1001, 8'h10, 16'd3);
        check("wrong_port_drop_count", 32'(drop_count), 32'd2);
        check("wrong_port_no_tx", 32'(bus.tx_valid), 32'd0);

        // Passive close.
        send_seg(RPORT, LPORT, 32'd111, 32'h0000_1001, 8'h11, 16'd0);
        check("finack_flags", 32'(bus.tx_flags), 32'h11);
        check("finack_seq", bus.tx_seq, 32'h0000_1001);
        check("finack_ack", bus.tx_ack, 32'd112);
        check("last_ack_state", 32'(conn_state), 32'd4);
        drain_tx();
        send_seg(RPORT, LPORT, 32'd112, 32'h0000_1002, 8'h10, 16'd0);
        check("listen_after_close", 32'(conn_state), 32'd1);

        // Sequence wrap.
        send_seg(RPORT, LPORT, 32'hFFFF_FFFB, 32'd0, 8'h02, 16'd0);
        check("wrap_synack_ack", bus.tx_ack, 32'hFFFF_FFFC);
        drain_tx();
        send_seg(RPORT, LPORT, 32'hFFFF_FFFC, 32'h0000_1001, 8'h10, 16'd0);
        send_seg(RPORT, LPORT, 32'hFFFF_FFFC, 32'h0000_1001, 8'h10, 16'd8);
        check("wrap_ack", bus.tx_ack, 32'd4);
        drain_tx();

        // RST while established.
        send_seg(RPORT, LPORT, 32'd4, 32'd0, 8'h04, 16'd0);
        check("rst_to_listen", 32'(conn_state), 32'd1);
        check("rst_not_dropped", 32'(drop_count), 32'd2);
        check("rst_no_tx", 32'(bus.tx_valid), 32'd0);

        // Handshake timeout.
        send_seg(RPORT, LPORT, 32'd500, 32'd0, 8'h02, 16'd0);
        check("timeout_entry", 32'(conn_state), 32'd2);
        repeat (TO - 1) @(negedge clk);
        check("timeout_hold", 32'(conn_state), 32'd2);
        @(negedge clk);
        check("timeout_expired", 32'(conn_state), 32'd1);

        // Reset with a response pending.
        bus.tx_ready = 1'b0;
        send_seg(RPORT, LPORT, 32'd700, 32'd0, 8'h02, 16'd0);
        check("pre_reset_tx_valid", 32'(bus.tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("reset_state", 32'(conn_state), 32'd0);
        check("reset_tx_seq", bus.tx_seq, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_tx_valid", 32'(bus.tx_valid), 32'd0);
        check("post_reset_listen", 32'(conn_state), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int          c;
            logic [15:0] src;
            @(negedge clk);
            c   = int'($urandom_range(0, 9));
            src = ($urandom_range(0, 9) == 0) ? 16'd4321 : ((m_st >= 2) ? m_rport : RPORT);
            bus.tx_ready         = ($urandom_range(0, 9) < 7);
            bus.meta_valid       = ($urandom_range(0, 9) < 6);
            bus.meta_src_port    = src;
            bus.meta_dst_port    = LPORT;
            bus.meta_seq_num     = $urandom;
            bus.meta_ack_num     = $urandom;
            bus.meta_flags       = 8'($urandom);
            bus.meta_payload_len = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
            case (c)
                0: begin bus.meta_flags = 8'h02; bus.meta_seq_num = 32'hFFFF_FFF0 + $urandom_range(0, 15); end
                1: bus.meta_flags = 8'h02;
                2, 3: begin
                    bus.meta_flags   = 8'h10;
                    bus.meta_ack_num = ($urandom_range(0, 3) == 0) ? m_snd + 32'd1 : m_snd;
                end
                4, 5: begin
                    bus.meta_seq_num = m_rcv;
                    bus.meta_flags   = ($urandom_range(0, 3) == 0) ? 8'h11 : 8'h10;
                end
                6: begin bus.meta_seq_num = m_rcv + $urandom_range(1, 1000); bus.meta_flags = 8'h10; end
                7: bus.meta_flags = 8'h04;
                8: bus.meta_dst_port = 16'd81;
                default: bus.meta_seq_num = ($urandom_range(0, 1) == 0) ? m_rcv : bus.meta_seq_num;
            endcase
            if ($urandom_range(0, 299) == 0) cfg_enable = 1'b0;
            else if (!cfg_enable && ($urandom_range(0, 7) == 0)) cfg_enable = 1'b1;
        end
        @(negedge clk);
        bus.meta_valid = 1'b0;
        bus.tx_ready   = 1'b1;
        cfg_enable     = 1'b1;
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
